// File: rtl/uc_seq.sv
// ============================================================================
//  Module   : uc_seq
//  Brief    : Sequenced control unit: Mealy decode plus IDLE/HALT/WAIT control
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uc_seq #(
    parameter int WAIT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       zero,
    input  logic       run,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we,
    output logic       wez,
    output logic [2:0] ALUOp,
    output logic       pc_en,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STALL  = 2'd2,
        HALTED = 2'd3
    } state_t;

    // The WAIT's own RUN cycle and the final STALL cycle both count toward
    // the total, hence the load value of WAIT_CYCLES-2.
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WAIT_CYCLES - 2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        s_inc     = 1'b1;
        s_inm     = 1'b0;
        we        = 1'b0;
        wez       = 1'b0;
        ALUOp     = 3'b000;
        pc_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) state_d = RUN;
            end
            RUN: begin
                pc_en = 1'b1;
                case (Opcode[5:3])
                    3'b000: begin
                        if (Opcode[2:0] == 3'b001) begin
                            pc_en   = 1'b0;
                            state_d = HALTED;
                        end else if (Opcode[2:0] == 3'b010 && WAIT_CYCLES > 1) begin
                            pc_en   = 1'b0;
                            cnt_d   = c_cnt_load;
                            state_d = STALL;
                        end
                    end
                    3'b001: begin
                        s_inm = 1'b1;
                        we    = 1'b1;
                    end
                    3'b010, 3'b011: begin
                        ALUOp = Opcode[2:0];
                        we    = 1'b1;
                        wez   = 1'b1;
                    end
                    3'b100: s_inc = 1'b0;
                    3'b101: s_inc = ~zero;
                    3'b110: s_inc = zero;
                    default: illegal_d = 1'b1;
                endcase
            end
            STALL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    state_d = RUN;
                end
            end
            HALTED: begin
                if (run) begin
                    pc_en   = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            state_d   = IDLE;
            cnt_d     = '0;
            illegal_d = 1'b0;
            s_inc     = 1'b1;
            s_inm     = 1'b0;
            we        = 1'b0;
            wez       = 1'b0;
            ALUOp     = 3'b000;
            pc_en     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        illegal_q <= illegal_d;
    end

    assign halted  = (state_q == HALTED);
    assign illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_uc_seq.sv
// ============================================================================
//  Module   : tb_uc_seq
//  Brief    : Scoreboard bench for uc_seq against a behavioural control model
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uc_seq;

    localparam int WC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'd0;
    logic       zero = 1'b0;
    logic       run = 1'b0;
    logic       s_inc, s_inm, we, wez, pc_en, halted, illegal;
    logic [2:0] ALUOp;

    uc_seq #(.WAIT_CYCLES(WC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .run(run),
        .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez), .ALUOp(ALUOp),
        .pc_en(pc_en), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [9:0] exp_q[$];

    // Model: operating mode, cycles already spent in the current WAIT,
    // and the sticky illegal flag.
    typedef enum int {M_IDLE, M_RUN, M_WAIT, M_HALT} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_elapsed = 0;
    bit    m_ill = 1'b0;

    // Packed expectation: {s_inc,s_inm,we,wez,ALUOp,pc_en,halted,illegal}
    task automatic model(input bit rst, input bit [5:0] op, input bit z,
                         input bit r, output logic [9:0] e);
        bit si = 1, sm = 0, w = 0, wz = 0, pc = 0;
        bit [2:0] alu = 3'b000;
        bit hl = (m_mode == M_HALT);
        bit il = m_ill;
        mode_t nm = m_mode;
        int    ne = m_elapsed;
        bit    ni = m_ill;
        if (rst) begin
            nm = M_IDLE; ne = 0; ni = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (r) nm = M_RUN;
                M_RUN: begin
                    pc = 1;
                    case (op[5:3])
                        3'd0: if (op[2:0] == 3'd1) begin
                                  pc = 0; nm = M_HALT;
                              end else if (op[2:0] == 3'd2 && WC > 1) begin
                                  pc = 0; nm = M_WAIT; ne = 1;
                              end
                        3'd1: begin sm = 1; w = 1; end
                        3'd2, 3'd3: begin alu = op[2:0]; w = 1; wz = 1; end
                        3'd4: si = 0;
                        3'd5: si = ~z;
                        3'd6: si = z;
                        default: ni = 1;
                    endcase
                end
                M_WAIT: if (m_elapsed == WC - 1) begin
                            pc = 1; nm = M_RUN;
                        end else ne = m_elapsed + 1;
                M_HALT: if (r) begin pc = 1; nm = M_RUN; end
                default: nm = M_IDLE;
            endcase
        end
        e = {si, sm, w, wz, alu, pc, hl, il};
        m_mode = nm; m_elapsed = ne; m_ill = ni;
    endtask

    task automatic step(input bit rst, input bit [5:0] op, input bit z, input bit r);
        logic [9:0] e;
        @(negedge clk);
        #1;
        reset = rst; Opcode = op; zero = z; run = r;
        model(rst, op, z, r, e);
        exp_q.push_back(e);
    endtask

    // Monitor: compares the presented outputs mid low-phase, after the driver.
    initial begin
        logic [9:0] act, e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {s_inc, s_inm, we, wez, ALUOp, pc_en, halted, illegal};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL cyc%0d outputs: got %b want %b (s_inc,s_inm,we,wez,alu,pc_en,halted,illegal)",
                             cyc, act, e);
                end
                cyc++;
            end
        end
    end

    initial begin
        int guard;
        repeat (3) step(1, 6'b010101, 0, 0);
        repeat (2) step(0, 6'b010101, 0, 0);
        step(0, 6'b000000, 0, 1);
        step(0, 6'b010101, 0, 0);
        step(0, 6'b101000, 1, 0);
        step(0, 6'b101000, 0, 0);
        step(0, 6'b110000, 1, 0);
        step(0, 6'b110000, 0, 0);
        step(0, 6'b100111, 0, 0);
        step(0, 6'b001010, 0, 0);
        step(0, 6'b000010, 0, 0);
        repeat (3) step(0, 6'($urandom), 1'($urandom), 0);
        step(0, 6'b000000, 0, 0);
        step(0, 6'b000001, 0, 1);
        repeat (5) step(0, 6'b010000, 0, 0);
        step(0, 6'b010000, 0, 1);
        step(0, 6'b011011, 0, 0);
        step(0, 6'b111011, 0, 0);
        repeat (3) step(0, 6'b000000, 0, 0);
        step(0, 6'b000010, 0, 0);
        step(0, 6'b000000, 0, 0);
        step(1, 6'b000000, 0, 0);
        step(0, 6'b010101, 0, 0);
        step(0, 6'b010101, 0, 1);
        step(0, 6'b000010, 0, 0);
        repeat (WC) step(0, 6'b011001, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit [5:0] op;
            op = 6'($urandom);
            if ($urandom_range(0, 3) == 0) op = {3'b000, 3'($urandom_range(0, 3))};
            if (op[5:3] == 3'b111 && $urandom_range(0, 3) != 0) op[5] = 1'b0;
            step($urandom_range(0, 60) == 0, op, 1'($urandom), $urandom_range(0, 2) == 0);
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #5;
        if (exp_q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
